unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter and sequencer that shares the single unified instruction/data memory port between the instruction-fetch requester and the load/store requester of the multicycle core. It accepts held requests, picks one winner, drives the memory address/write-data/write-enable for exactly one access cycle and captures the read data. It then returns a one-cycle done pulse to the winner. The block sits between the core's fetch and load/store units and the memory, which still decodes Address[22] internally.

## Interface
- DATA_WIDTH, 32, width of addresses and data words
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  DATA_WIDTH  fetch byte address
- if_done  out  1  one-cycle pulse: fetch complete
- if_err  out  1  valid with if_done: fetch address misaligned
- if_rdata  out  DATA_WIDTH  fetched word; registered, stable from if_done until the next fetch completes
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1 = store, 0 = load; held with d_req
- d_addr  in  DATA_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_err  out  1  valid with d_done: data address misaligned
- d_rdata  out  DATA_WIDTH  load data; registered, same stability rule as if_rdata
- mem_addr  out  DATA_WIDTH  memory address (registered)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_we  out  1  memory write enable (registered); high for exactly one cycle per store
- mem_rdata  in  DATA_WIDTH  memory read data, combinational from mem_addr
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner, latch its address, write data and we, and go to ACCESS.
  - A misaligned winner (addr[1:0] != 0) skips ACCESS and goes to DONE with err set. No memory cycle occurs and mem_we stays 0.
- ACCESS:
  - mem_addr/mem_wdata hold the latched values.
  - mem_we = 1 if a store was latched.
  - At the end of the cycle: for a load or fetch, capture mem_rdata into the winner's rdata register; go to DONE.
- DONE:
  - Pulse the winner's done; err is valid with it; go to IDLE.
  - The loser's request stays pending and is evaluated in the next IDLE cycle.
- Arbitration when both requests are high in IDLE: data wins (fixed priority, default build).
- The requester must deassert req no later than the cycle after its done. A req still high in the IDLE cycle after DONE is treated as a new request.
- mem_addr keeps its last value while idle. mem_we is 0 outside ACCESS.
- The non-winning port's rdata register never changes.
- Reset values: state IDLE, all done/err 0, rdata registers 0, mem_addr 0, mem_wdata 0, mem_we 0, busy 0, round-robin pointer set so fetch wins the first conflict.
- Reset asserted during ACCESS:
  - A store in progress commits, because memory samples at the same edge.
  - No done is issued.
  - The requester must reissue the request.

## Timing
- Request sampled high in IDLE at edge N:
  - ACCESS occupies cycle N+1.
  - done is high in cycle N+2.
  - Minimum request-to-done latency is 2 cycles.
- Misaligned request: done+err in cycle N+1.
- Throughput: one access per 3 cycles. Back-to-back conflicting requests alternate IDLE→ACCESS→DONE with no extra bubble beyond IDLE.
- rdata is valid in the same cycle as done, from a register and not from mem_rdata.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: on conflict, the port not granted last wins. The pointer updates only on a grant where both requests were high.
  - Undefined: fixed data priority, and the pointer logic is not compiled. Worst-case fetch wait with continuous data traffic is unbounded.

## Structure
- Package unified_mem_arbiter_pkg: state enum (IDLE, ACCESS, DONE), port-id encoding (PORT_IF = 0, PORT_D = 1), ALIGN_MASK = 2'b11.
- Sub-module mem_arb_pick: combinational winner selection from if_req, d_req and the last-grant pointer. Its pointer input is tied off when MEM_ARB_ROUND_ROBIN_EN is undefined.

## Test plan
- Single fetch of if_addr 0x0040_0000, mem_rdata 0x2008_0005 → if_done at N+2, if_rdata = 0x2008_0005, mem_we never 1.
- Store d_addr 0x1001_0004, d_wdata 0xDEAD_BEEF:
  - mem_we high for exactly cycle N+1 with mem_addr 0x1001_0004.
  - d_done at N+2.
  - A following load from the same address returns 0xDEAD_BEEF.
- if_req and d_req raised in the same cycle and held:
  - Default build: d_done precedes if_done; if_done arrives 3 cycles after d_done.
  - With MEM_ARB_ROUND_ROBIN_EN: if_done is first, and grants alternate over 4 continuous requests.
- Misaligned load d_addr 0x1001_0002 → d_done and d_err in cycle N+1, mem_we 0, d_rdata unchanged.
- reset asserted in the ACCESS cycle of a store → the memory word is updated, no d_done, all outputs at reset values the next cycle, busy 0.
- Load immediately followed by a fetch → if_rdata is unchanged during the load, and d_rdata is unchanged during the fetch.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter_pkg
// Description : Shared types and constants for the unified memory arbiter:
//               sequencer states, requester port ids, alignment mask and the
//               grant record produced by the winner picker.
//               Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
// Revision    : 1.0 - initial release
// ============================================================================
package unified_mem_arbiter_pkg;

    // Sequencer states: wait for a request, one memory cycle, report back
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Requester identity; also the value stored in the last-grant pointer
    typedef logic port_id_t;

    localparam port_id_t   PORT_IF    = 1'b0;
    localparam port_id_t   PORT_D     = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Result of arbitration in one IDLE cycle
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } grant_t;

    // Word accesses only: any set low address bit is a misaligned request
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection between the fetch and the
//               load/store requester. On a conflict the port that was NOT
//               granted last wins; tying the pointer to PORT_IF therefore
//               yields fixed data priority.
//               Optional feature macro (in the parent): MEM_ARB_ROUND_ROBIN_EN
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import unified_mem_arbiter_pkg::*;
(
    input  logic     if_req,
    input  logic     d_req,
    input  port_id_t last_grant,
    output grant_t   grant
);

    // Pick a single winner; a contested grant goes to the other port
    always_comb begin
        grant.valid = if_req | d_req;
        if (if_req && d_req) begin
            grant.port = ~last_grant;
        end else if (d_req) begin
            grant.port = PORT_D;
        end else begin
            grant.port = PORT_IF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares the single unified instruction/data memory port
//               between instruction fetch and load/store. A winner is picked
//               in IDLE, one registered memory cycle is run in ACCESS, and a
//               one-cycle done (with err) is returned in DONE. Misaligned
//               requests skip the memory cycle entirely.
//               Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//                 defined   - contested grants alternate between the ports
//                 undefined - data port always wins a conflict
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction fetch requester
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic                  if_err,
    output logic [DATA_WIDTH-1:0] if_rdata,
    // load/store requester
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    // unified memory port
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // status
    output logic                  busy
);

    arb_state_t            state_q,     state_d;
    port_id_t              win_port_q,  win_port_d;
    logic                  win_we_q,    win_we_d;
    logic                  err_q,       err_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
    logic [DATA_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q,    mem_we_d;

    grant_t                grant;
    port_id_t              pick_ptr;
    logic [DATA_WIDTH-1:0] grant_addr;
    logic                  grant_mis;
    logic                  grant_we;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (pick_ptr),
        .grant      (grant)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_id_t last_grant_q, last_grant_d;

    // Remember the winner of the most recent contested grant only
    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && if_req && d_req) begin
            last_grant_d = grant.port;
        end
    end

    // Pointer register; reset value lets fetch win the first conflict
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign pick_ptr = last_grant_q;
`else
    // Fixed priority: a constant "fetch won last" makes data win every conflict
    assign pick_ptr = PORT_IF;
`endif

    // Request attributes of the current winner
    always_comb begin
        grant_addr = (grant.port == PORT_D) ? d_addr : if_addr;
        grant_we   = (grant.port == PORT_D) && d_we;
        grant_mis  = is_misaligned(grant_addr[1:0]);
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // All flops update together; reset aborts any access without a done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            win_port_q  <= PORT_IF;
            win_we_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_port_q  <= win_port_d;
            win_we_q    <= win_we_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    // Next state: misaligned winners bypass the memory cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant.valid) begin
                    state_d = grant_mis ? DONE : ACCESS;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the winner in IDLE, capture read data at
    // the end of ACCESS into the winner's register only
    always_comb begin
        win_port_d  = win_port_q;
        win_we_d    = win_we_q;
        err_d       = err_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant.valid) begin
                    win_port_d = grant.port;
                    win_we_d   = grant_we;
                    err_d      = grant_mis;
                    // The memory port only moves when a real access follows
                    if (!grant_mis) begin
                        mem_addr_d = grant_addr;
                        mem_we_d   = grant_we;
                        if (grant.port == PORT_D) begin
                            mem_wdata_d = d_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!win_we_q) begin
                    if (win_port_q == PORT_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs: done pulses decoded from DONE, everything else from registers
    always_comb begin
        busy      = (state_q != IDLE);
        if_done   = (state_q == DONE) && (win_port_q == PORT_IF);
        d_done    = (state_q == DONE) && (win_port_q == PORT_D);
        if_err    = if_done && err_q;
        d_err     = d_done && err_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_we    = mem_we_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Self-checking bench for unified_mem_arbiter. A transaction
//               level model predicts done/err timing, grant order and read
//               data from the access rules; a behavioural memory answers the
//               DUT's memory port.
//               Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_done, if_err, d_done, d_err, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    // Memory behind the DUT, and the model's own view of memory contents
    bit   [31:0] env_mem [256];
    bit   [31:0] ref_mem [256];
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          rr_last_d;   // 1: data port won the last contested grant

    always #5 clk = ~clk;

    assign mem_rdata = env_mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we === 1'b1) env_mem[mem_addr[9:2]] <= mem_wdata;
    end

    unified_mem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_err    (if_err),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_if_done",  {31'b0, if_done}, 32'd0);
        chk("rst_d_done",   {31'b0, d_done},  32'd0);
        chk("rst_if_err",   {31'b0, if_err},  32'd0);
        chk("rst_d_err",    {31'b0, d_err},   32'd0);
        chk("rst_if_rdata", if_rdata,         32'd0);
        chk("rst_d_rdata",  d_rdata,          32'd0);
        chk("rst_mem_addr", mem_addr,         32'd0);
        chk("rst_mem_wdata", mem_wdata,       32'd0);
        chk("rst_mem_we",   {31'b0, mem_we},  32'd0);
        chk("rst_busy",     {31'b0, busy},    32'd0);
    endtask

    task automatic model_reset();
        exp_if_rdata = 32'd0;
        exp_d_rdata  = 32'd0;
        rr_last_d    = 1'b1;
    endtask

    // One transaction: fetch and/or data request raised together, each held
    // until its own done. Completion cycles follow from the access rules:
    // aligned takes 2 cycles, misaligned 1, the loser waits one IDLE cycle.
    task automatic txn(input bit use_if, input logic [31:0] ia,
                       input bit use_d, input bit we,
                       input logic [31:0] da, input logic [31:0] wd);
        bit if_mis, d_mis, if_first;
        int if_lat, d_lat, if_t, d_t, tmax;
        bit e_busy, e_we;
        if_mis = (ia[1:0] != 2'b00);
        d_mis  = (da[1:0] != 2'b00);
        if_lat = if_mis ? 1 : 2;
        d_lat  = d_mis ? 1 : 2;
        if_t   = 0;
        d_t    = 0;
        if (use_if && use_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if_first  = rr_last_d;
            rr_last_d = !if_first;
`else
            if_first  = 1'b0;
`endif
            if (if_first) begin
                if_t = if_lat;
                d_t  = if_t + 1 + d_lat;
            end else begin
                d_t  = d_lat;
                if_t = d_t + 1 + if_lat;
            end
        end else begin
            if (use_if) if_t = if_lat;
            if (use_d)  d_t  = d_lat;
        end
        tmax = ((if_t > d_t) ? if_t : d_t) + 1;

        if_req  = use_if;
        if_addr = ia;
        d_req   = use_d;
        d_we    = we;
        d_addr  = da;
        d_wdata = wd;
        for (int k = 1; k <= tmax; k++) begin
            tick();
            if (k == if_t && !if_mis) exp_if_rdata = ref_mem[ia[9:2]];
            if (k == d_t && !d_mis) begin
                if (we) ref_mem[da[9:2]] = wd;
                else    exp_d_rdata = ref_mem[da[9:2]];
            end
            e_busy = (use_if && k >= if_t - if_lat + 1 && k <= if_t) ||
                     (use_d  && k >= d_t  - d_lat  + 1 && k <= d_t);
            e_we   = use_d && we && !d_mis && (k == d_t - 1);
            chk("if_done",  {31'b0, if_done}, {31'b0, (k == if_t)});
            chk("d_done",   {31'b0, d_done},  {31'b0, (k == d_t)});
            chk("if_err",   {31'b0, if_err},  {31'b0, (k == if_t) && if_mis});
            chk("d_err",    {31'b0, d_err},   {31'b0, (k == d_t) && d_mis});
            chk("busy",     {31'b0, busy},    {31'b0, e_busy});
            chk("mem_we",   {31'b0, mem_we},  {31'b0, e_we});
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("d_rdata",  d_rdata,  exp_d_rdata);
            if (e_we) begin
                chk("st_addr",  mem_addr,  da);
                chk("st_wdata", mem_wdata, wd);
            end
            if (use_if && !if_mis && k == if_t - 1) chk("if_mem_addr", mem_addr, ia);
            if (use_d && !d_mis && k == d_t - 1)    chk("d_mem_addr",  mem_addr, da);
            if (k == if_t) if_req = 1'b0;
            if (k == d_t)  d_req  = 1'b0;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    // Both requesters keep their loads asserted for four grants; every IDLE
    // cycle is a conflict. Grant g occupies cycles 3g+1 (ACCESS), 3g+2 (DONE)
    // and 3g+3 (IDLE).
    task automatic saturate(input logic [31:0] ia, input logic [31:0] da);
        bit win_d [4];
        bit e_ifd, e_dd;
        int g, ph;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_d[i]  = !rr_last_d;
`else
            win_d[i]  = 1'b1;
`endif
            rr_last_d = win_d[i];
        end
        if_req  = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        if_addr = ia;
        d_addr  = da;
        for (int k = 1; k <= 12; k++) begin
            tick();
            g  = (k - 1) / 3;
            ph = (k - 1) % 3;
            e_ifd = (ph == 1) && !win_d[g];
            e_dd  = (ph == 1) && win_d[g];
            if (e_ifd) exp_if_rdata = ref_mem[ia[9:2]];
            if (e_dd)  exp_d_rdata  = ref_mem[da[9:2]];
            chk("sat_if_done",  {31'b0, if_done}, {31'b0, e_ifd});
            chk("sat_d_done",   {31'b0, d_done},  {31'b0, e_dd});
            chk("sat_busy",     {31'b0, busy},    {31'b0, (ph != 2)});
            chk("sat_mem_we",   {31'b0, mem_we},  32'd0);
            chk("sat_if_rdata", if_rdata, exp_if_rdata);
            chk("sat_d_rdata",  d_rdata,  exp_d_rdata);
            if (k == 11) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
    endtask

    int          kind;
    logic [31:0] r_ia, r_da, r_wd;
    bit          r_we;

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        if_addr = 32'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        model_reset();
        tick();
        tick();
        check_reset_values();
        reset = 1'b0;
        tick();

        // Preload the fetch word through the data port, then fetch it
        txn(0, 32'h0, 1, 1, 32'h0040_0000, 32'h2008_0005);
        txn(1, 32'h0040_0000, 0, 0, 32'h0, 32'h0);

        // Store then load back the same word
        txn(0, 32'h0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF);
        txn(0, 32'h0, 1, 0, 32'h1001_0004, 32'h0);

        // Simultaneous requests held until done
        txn(1, 32'h0040_0000, 1, 0, 32'h1001_0004, 32'h0);

        // Misaligned load: done+err after one cycle, no memory cycle
        txn(0, 32'h0, 1, 0, 32'h1001_0002, 32'h0);

        // Load followed directly by a fetch
        txn(0, 32'h0, 1, 0, 32'h1001_0004, 32'h0);
        txn(1, 32'h0040_0000, 0, 0, 32'h0, 32'h0);

        // Continuous contention over four grants
        saturate(32'h0040_0000, 32'h1001_0004);
        tick();

        // Reset during the ACCESS cycle of a store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1001_0008;
        d_wdata = 32'hCAFE_F00D;
        tick();
        chk("rsta_mem_we",   {31'b0, mem_we}, 32'd1);
        chk("rsta_mem_addr", mem_addr, 32'h1001_0008);
        reset = 1'b1;
        d_req = 1'b0;
        tick();
        check_reset_values();
        reset = 1'b0;
        model_reset();
        ref_mem[8'd2] = 32'hCAFE_F00D;
        tick();
        txn(0, 32'h0, 1, 0, 32'h1001_0008, 32'h0);

        // Randomised mix of single, conflicting, store, load and misaligned
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            r_ia = 32'h1001_0000 | (32'($urandom_range(0, 15)) << 2);
            r_da = 32'h1001_0000 | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) r_ia = r_ia | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) r_da = r_da | 32'($urandom_range(1, 3));
            r_we = ($urandom_range(0, 1) == 1);
            r_wd = $urandom;
            txn((kind != 1), r_ia, (kind != 0), r_we, r_da, r_wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
